// File: rtl/moving_average_scheduler.sv
// Round-robin time-shared 3-tap signed moving average over NCH sample channels.
// Optional feature: define MA_SCHED_FLUSH_EN to add the flush input that clears all histories.
module moving_average_scheduler #(
  parameter int NCH = 4,
  parameter int DW  = 8
) (
  input  logic                   system1000,
  input  logic                   system1000_rst,
  input  logic [NCH-1:0]         in_valid,
  input  logic [NCH*DW-1:0]      in_data,
  output logic [NCH-1:0]         in_ready,
  output logic                   out_valid,
  output logic [DW-1:0]          out_data,
  output logic [$clog2(NCH)-1:0] out_chan,
`ifdef MA_SCHED_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic                   out_ready
);

  localparam int CW = $clog2(NCH);
  localparam logic signed [DW+1:0] DIVISOR = (DW+2)'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUM,
    S_DIV,
    S_HOLD
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         chan_q, chan_d;
  logic [CW-1:0]         out_chan_q, out_chan_d;
  logic signed [DW-1:0]  x_q, x_d;
  logic signed [DW-1:0]  out_data_q, out_data_d;
  logic signed [DW+1:0]  sum_q, sum_d;
  logic signed [DW-1:0]  h1_q [NCH];
  logic signed [DW-1:0]  h1_d [NCH];
  logic signed [DW-1:0]  h2_q [NCH];
  logic signed [DW-1:0]  h2_d [NCH];

  logic signed [DW-1:0]  samples [NCH];
  logic                  grant_found;
  logic [CW-1:0]         grant_chan;
  int                    scan_idx;
  logic                  clear_hist;

`ifdef MA_SCHED_FLUSH_EN
  logic flush_pend_q, flush_pend_d;
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_unpack
    assign samples[k] = in_data[k*DW +: DW];
  end

  function automatic logic signed [DW+1:0] sext(input logic signed [DW-1:0] v);
    return {{2{v[DW-1]}}, v};
  endfunction

  // Round-robin search: first requesting channel at or above ptr, with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_chan  = '0;
    scan_idx    = 0;
    for (int i = 0; i < NCH; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= NCH) scan_idx = scan_idx - NCH;
      if (!grant_found && in_valid[CW'(scan_idx)]) begin
        grant_found = 1'b1;
        grant_chan  = CW'(scan_idx);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (state_q == S_IDLE && grant_found) in_ready[grant_chan] = 1'b1;
  end

  assign out_valid = (state_q == S_HOLD);
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case can infer a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    chan_d     = chan_q;
    x_d        = x_q;
    sum_d      = sum_q;
    out_data_d = out_data_q;
    out_chan_d = out_chan_q;
    h1_d       = h1_q;
    h2_d       = h2_q;
    clear_hist = 1'b0;
`ifdef MA_SCHED_FLUSH_EN
    flush_pend_d = flush_pend_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // A grant always pairs with a valid request, so grant_found is the handshake.
        if (grant_found) begin
          x_d     = samples[grant_chan];
          chan_d  = grant_chan;
          ptr_d   = (grant_chan == CW'(NCH-1)) ? '0 : grant_chan + 1'b1;
          state_d = S_SUM;
        end
`ifdef MA_SCHED_FLUSH_EN
        if (flush) clear_hist = 1'b1;
`endif
      end

      S_SUM: begin
        sum_d        = sext(x_q) + sext(h1_q[chan_q]) + sext(h2_q[chan_q]);
        h2_d[chan_q] = h1_q[chan_q];
        h1_d[chan_q] = x_q;
        state_d      = S_DIV;
`ifdef MA_SCHED_FLUSH_EN
        if (flush) flush_pend_d = 1'b1;
`endif
      end

      S_DIV: begin
        // Signed division truncates toward zero; the quotient always fits in DW bits.
        out_data_d = DW'(sum_q / DIVISOR);
        out_chan_d = chan_q;
        state_d    = S_HOLD;
`ifdef MA_SCHED_FLUSH_EN
        // A flush seen during SUM/DIV lands here, overwriting the update just made.
        if (flush || flush_pend_q) clear_hist = 1'b1;
        flush_pend_d = 1'b0;
`endif
      end

      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
`ifdef MA_SCHED_FLUSH_EN
        if (flush) clear_hist = 1'b1;
`endif
      end

      default: state_d = S_IDLE;
    endcase

    if (clear_hist) begin
      h1_d = '{default: '0};
      h2_d = '{default: '0};
    end
  end

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      // NOTE: the history arrays are reset like any other state because a reset must clear every channel's past.
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      chan_q     <= '0;
      x_q        <= '0;
      sum_q      <= '0;
      out_data_q <= '0;
      out_chan_q <= '0;
      h1_q       <= '{default: '0};
      h2_q       <= '{default: '0};
`ifdef MA_SCHED_FLUSH_EN
      flush_pend_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      chan_q     <= chan_d;
      x_q        <= x_d;
      sum_q      <= sum_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      h1_q       <= h1_d;
      h2_q       <= h2_d;
`ifdef MA_SCHED_FLUSH_EN
      flush_pend_q <= flush_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_moving_average_scheduler.sv
// Randomized and directed bench for moving_average_scheduler against a per-channel average model.
module tb_moving_average_scheduler;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int CW  = $clog2(NCH);

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_chan;
  logic              out_ready;
`ifdef MA_SCHED_FLUSH_EN
  logic              flush;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: last and second-to-last accepted sample per channel, plus rotation pointer.
  int m_last  [NCH];
  int m_prev  [NCH];
  int m_ptr;

  moving_average_scheduler #(.NCH(NCH), .DW(DW)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_chan       (out_chan),
`ifdef MA_SCHED_FLUSH_EN
    .flush          (flush),
`endif
    .out_ready      (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NCH; k++) begin
      m_last[k] = 0;
      m_prev[k] = 0;
    end
  endtask

  function automatic int model_grant(input logic [NCH-1:0] req);
    for (int i = 0; i < NCH; i++) begin
      if (req[(m_ptr + i) % NCH]) return (m_ptr + i) % NCH;
    end
    return -1;
  endfunction

  task automatic model_accept(input int ch, input int x, output int avg);
    avg        = (x + m_last[ch] + m_prev[ch]) / 3;
    m_prev[ch] = m_last[ch];
    m_last[ch] = x;
    m_ptr      = (ch + 1) % NCH;
  endtask

  function automatic logic [NCH*DW-1:0] pack_one(input int ch, input int x);
    logic [NCH*DW-1:0] v;
    logic [DW-1:0]     s;
    v = (NCH*DW)'($urandom);
    s = DW'(x);
    v[ch*DW +: DW] = s;
    return v;
  endfunction

  function automatic int sample_of(input logic [NCH*DW-1:0] d, input int ch);
    logic signed [DW-1:0] s;
    s = d[ch*DW +: DW];
    return int'(s);
  endfunction

  // Starts and ends on a falling edge with the DUT in IDLE; hold = extra cycles out_ready stays low.
  task automatic run_txn(input logic [NCH-1:0] req, input logic [NCH*DW-1:0] data,
                         input int hold, output int got_data, output int got_chan);
    int g;
    int exp;
    logic signed [DW-1:0] od;
    in_valid  = req;
    in_data   = data;
    out_ready = 1'b0;
    #1;
    g = model_grant(req);
    check("grant", int'(in_ready), 1 << g);
    model_accept(g, sample_of(data, g), exp);
    @(negedge clk);
    in_data = (NCH*DW)'($urandom);
    check("sum_ready", int'(in_ready), 0);
    check("sum_valid", int'(out_valid), 0);
    @(negedge clk);
    check("div_valid", int'(out_valid), 0);
    @(negedge clk);
    od       = out_data;
    got_data = int'(od);
    got_chan = int'(out_chan);
    check("lat_valid", int'(out_valid), 1);
    check("out_data", got_data, exp);
    check("out_chan", got_chan, g);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      od = out_data;
      check("bp_valid", int'(out_valid), 1);
      check("bp_data", int'(od), exp);
      check("bp_chan", int'(out_chan), g);
      check("bp_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = '0;
    check("release_valid", int'(out_valid), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_chan", int'(out_chan), 0);
    check("rst_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    m_ptr = 0;
    @(negedge clk);
  endtask

  int gd, gc;
  int ch3_seen;
  int exp_ch3 [4] = '{30, 60, 90, 90};
  int exp_ch0 [4] = '{1, 3, 6, 9};
  int exp_ch1 [4] = '{0, 0, -43, -85};
  int in_ch0  [4] = '{3, 6, 9, 12};
  int in_ch1  [4] = '{-1, -1, -128, -128};
  logic [NCH*DW-1:0] fair_data;
  logic [NCH-1:0]    rmask;
  logic signed [DW-1:0] od;

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef MA_SCHED_FLUSH_EN
    flush     = 1'b0;
`endif
    @(negedge clk);
    do_reset();

    // Fairness: every channel requests continuously, channel k sends 30*k.
    for (int k = 0; k < NCH; k++) fair_data[k*DW +: DW] = DW'(30 * k);
    ch3_seen = 0;
    for (int t = 0; t < 16; t++) begin
      run_txn('1, fair_data, 0, gd, gc);
      check("fair_chan", gc, t % NCH);
      if (gc == 3) begin
        check("fair_ch3", gd, exp_ch3[ch3_seen]);
        ch3_seen++;
      end
    end

    for (int t = 0; t < 4; t++) begin
      run_txn(NCH'(1), pack_one(0, in_ch0[t]), 0, gd, gc);
      check("ch0_const", gd, exp_ch0[t]);
    end

    // Reset while channel 2's sample sits in DIV: it must vanish and histories clear.
    in_valid = NCH'(4);
    in_data  = pack_one(2, 50);
    @(negedge clk);
    in_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstdiv_valid", int'(out_valid), 0);
    check("rstdiv_data", int'(out_data), 0);
    check("rstdiv_chan", int'(out_chan), 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    m_ptr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstdiv_noout", int'(out_valid), 0);
    end
    run_txn(NCH'(4), pack_one(2, 9), 0, gd, gc);
    check("rstdiv_next", gd, 3);

    for (int t = 0; t < 4; t++) begin
      run_txn(NCH'(2), pack_one(1, in_ch1[t]), 0, gd, gc);
      check("ch1_const", gd, exp_ch1[t]);
    end

    run_txn(NCH'(8), pack_one(3, $urandom_range(0, 255)), 10, gd, gc);

`ifdef MA_SCHED_FLUSH_EN
    run_txn(NCH'(4), pack_one(2, 90), 0, gd, gc);
    run_txn(NCH'(4), pack_one(2, 90), 0, gd, gc);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
    run_txn(NCH'(4), pack_one(2, 90), 0, gd, gc);
    check("flush_out", gd, 30);
`endif

    for (int t = 0; t < 60; t++) begin
      rmask = NCH'($urandom_range(1, (1 << NCH) - 1));
      run_txn(rmask, (NCH*DW)'($urandom), $urandom_range(0, 3), gd, gc);
    end

    // Idle with no requests: nothing is granted or emitted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ready", int'(in_ready), 0);
      check("idle_valid", int'(out_valid), 0);
    end
    od = out_data;
    if (od == od) begin end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/moving_average_scheduler.md
# moving_average_scheduler

Time-shares a single 3-tap signed moving-average datapath between `NCH` independent sample channels. Each channel keeps its own 3-sample history. A round-robin arbiter admits one sample at a time through a valid/ready handshake. The averaged result leaves on a single output port tagged with its channel number, with backpressure. The block sits between the per-channel sample sources and the downstream consumer, replacing one filter instance per channel.

## Interface
Parameters:
- `NCH`, 4: number of requesting channels (2..8).
- `DW`, 8: sample width, signed two's complement.

Ports:
- `system1000`, input, 1: clock; all logic on the rising edge.
- `system1000_rst`, input, 1: asynchronous reset, active high.
- `in_valid`, input, `NCH`: per-channel sample-valid.
- `in_data`, input, `NCH*DW`: channel k sample is in bits `[k*DW +: DW]`.
- `in_ready`, output, `NCH`: one-hot (or zero) grant; a sample transfers when `in_valid[k] && in_ready[k]`.
- `out_valid`, output, 1: result available.
- `out_data`, output, `DW`: signed average.
- `out_chan`, output, `$clog2(NCH)`: channel the result belongs to.
- `out_ready`, input, 1: consumer accepts the result.
- `flush`, input, 1: present only with `MA_SCHED_FLUSH_EN` (see Configuration).

## Operation
- **Per-channel history:** `h1[k]` and `h2[k]` hold the two previous samples of channel k. Both reset to 0.
- **IDLE state:**
  - The arbiter picks the first k with `in_valid[k]`, searching from `ptr` upward with wrap.
  - `in_ready = onehot(k)` combinationally; if no request is pending, `in_ready = 0`.
  - On handshake: latch sample `x` and channel `c`, set `ptr <= c+1 mod NCH`, go to SUM.
- **SUM state:**
  - `sum = x + h1[c] + h2[c]`, sign-extended to `DW+2` bits, so no overflow is possible.
  - History update: `h2[c] <= h1[c]`, `h1[c] <= x`.
  - Go to DIV.
- **DIV state:** `q = sum / 3`, truncating toward zero. `|q|` never exceeds the `DW`-bit range. Register `out_data <= q[DW-1:0]` and `out_chan <= c`, then go to HOLD.
- **HOLD state:**
  - `out_valid = 1`.
  - `out_data` and `out_chan` stay stable until `out_ready`.
  - On `out_ready`, go to IDLE.
- **Outside IDLE:** `in_ready = 0`, so only one sample is in flight.
- **Channel isolation:** channels never interact. A request from channel j never changes `h1`/`h2` of any other channel.
- **Reset values:**
  - `in_ready = 0`, `out_valid = 0`, `out_data = 0`, `out_chan = 0`.
  - All histories 0, `ptr = 0`, state IDLE.
- **Reset mid-operation:** a sample in flight is discarded and no output is produced for it. Histories clear.

## Timing
- **Latency:** handshake at cycle T (IDLE), SUM at T+1, DIV at T+2, `out_valid` high from T+3.
- **Throughput:** earliest next handshake is the cycle after the `out_ready` cycle. Best case is one sample per 4 cycles.
- **Backpressure:** `out_valid` may be held high indefinitely. Results are never dropped or overwritten.
- **Input stability:** `in_valid` may deassert without handshake. `in_data` is sampled only on the handshake cycle.
- **Fairness:** with every channel requesting continuously, grants rotate 0,1,..,NCH-1,0,... A channel waits at most NCH-1 other grants.

## Configuration
- `MA_SCHED_FLUSH_EN` defined:
  - Adds the `flush` input.
  - `flush` high for one cycle in IDLE or HOLD clears all `h1`/`h2` to 0 on the next edge. In HOLD, the pending output is unaffected.
  - `flush` in SUM or DIV is held pending and applied on entry to HOLD. The in-flight update is therefore overwritten by zeros.
  - `ptr` is not affected.
- `MA_SCHED_FLUSH_EN` undefined: there is no `flush` port. Histories clear only on reset.

## Test plan
- **Channel 0 alone:** samples 3, 6, 9, 12 with `out_ready = 1` -> `out_data` 1, 3, 6, 9, each with `out_chan = 0` and first `out_valid` 3 cycles after its handshake.
- **Negative values, truncation:** channel 1 sends -1, -1, -128, -128 -> 0, 0, -43, -85.
- **Fairness:** all 4 channels hold `in_valid`, channel k sending constant 30·k -> `out_chan` sequence 0,1,2,3,0,...; channel 3 outputs 30, 60, 90, 90.
- **Backpressure:** `out_ready = 0` for 10 cycles after `out_valid` -> `out_data`/`out_chan` stable; `in_ready = 0` throughout; exactly one output on release.
- **Reset in DIV:** assert `system1000_rst` while in DIV -> outputs 0 immediately; no result emitted; the next sample 9 on that channel outputs 3.
- **Flush (`MA_SCHED_FLUSH_EN` only):** channel 2 sends 90, 90, then pulse `flush` in IDLE, then sends 90 -> the third output is 30.
